// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring counter supervisor and its decoder.
package ring_pkg;
  localparam int ERR_W = 8;
  localparam int MAX_N = 64;

  typedef enum logic [1:0] {IDLE, SETTLE, TRACK, FAULT} state_t;

  typedef struct packed {
    logic       legal;
    logic [5:0] idx;
  } dec_t;

  // Legal means exactly one of the low n bits is set; idx is that bit's position.
  function automatic dec_t onehot_to_idx(input logic [MAX_N-1:0] vec, input int n);
    dec_t r;
    int   ones;
    r    = '0;
    ones = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && vec[i]) begin
        ones++;
        r.idx = i[5:0];
      end
    end
    r.legal = (ones == 1);
    return r;
  endfunction
endpackage

// File: rtl/ring_decode.sv
// Combinational one-hot validator/encoder for a [0:N-1] ring vector.
module ring_decode
  import ring_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [0:N-1]  ring,
  output logic          legal,
  output logic [IW-1:0] idx
);
  logic [MAX_N-1:0] vec;
  dec_t             dec;

  always_comb begin
    vec = '0;
    for (int i = 0; i < N; i++) vec[i] = ring[i];
    dec = onehot_to_idx(vec, N);
  end

  assign legal = dec.legal;
  assign idx   = IW'(dec.idx);
endmodule

// File: rtl/ring_counter_supervisor.sv
// Tracks a one-hot ring counter, counts rotations, and restarts the ring via
// start_req on illegal or skipped states; goes sticky-FAULT after ERR_LIMIT errors.
module ring_counter_supervisor
  import ring_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int CNT_W     = 8,
  parameter  int ERR_LIMIT = 3,
  localparam int IW        = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:N-1]     ring_in,
  input  logic             clear_fault,
  output logic             start_req,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] rot_count,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             fault
);
  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic [IW-1:0]    index_q, index_d, exp_q, exp_d;
  logic             valid_q, valid_d, wrap_q, wrap_d;
  logic [CNT_W-1:0] rot_q, rot_d;
  logic             errp_q, errp_d, fault_q, fault_d;
  logic [ERR_W-1:0] errc_q, errc_d, err_inc;
  logic             err_event, dec_legal;
  logic [IW-1:0]    dec_idx;

  ring_decode #(.N(N)) u_dec (.ring(ring_in), .legal(dec_legal), .idx(dec_idx));

  // An error in the same cycle as clear_fault counts from zero.
  assign err_inc = clear_fault      ? ERR_W'(1) :
                   (errc_q == '1)   ? errc_q    : errc_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    index_d   = index_q;
    exp_d     = exp_q;
    valid_d   = valid_q;
    wrap_d    = 1'b0;
    rot_d     = rot_q;
    errp_d    = 1'b0;
    errc_d    = clear_fault ? '0 : errc_q;
    err_event = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = SETTLE;
        start_d = 1'b1;
      end
      SETTLE: begin
        start_d = 1'b1;
        if (dec_legal && dec_idx == '0) begin
          state_d = TRACK;
          start_d = 1'b0;
          index_d = '0;
          valid_d = 1'b1;
          exp_d   = IW'(1);
        end else begin
          err_event = 1'b1;
        end
      end
      TRACK: begin
        start_d = 1'b0;
        if (dec_legal && dec_idx == exp_q) begin
          index_d = exp_q;
          exp_d   = (exp_q == IW'(N-1)) ? '0 : exp_q + 1'b1;
          if (exp_q == IW'(N-1)) begin
            wrap_d = 1'b1;
            rot_d  = rot_q + 1'b1;
          end
        end else begin
          err_event = 1'b1;
          valid_d   = 1'b0;
          state_d   = SETTLE;
          start_d   = 1'b1;
        end
      end
      FAULT: begin
        start_d = 1'b0;
        valid_d = 1'b0;
        if (clear_fault) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (err_event) begin
      errp_d = 1'b1;
      errc_d = err_inc;
      if (err_inc >= ERR_W'(ERR_LIMIT)) begin
        state_d = FAULT;
        start_d = 1'b0;
        valid_d = 1'b0;
      end
    end
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      index_q <= '0;
      exp_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      rot_q   <= '0;
      errp_q  <= 1'b0;
      errc_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      index_q <= index_d;
      exp_q   <= exp_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      rot_q   <= rot_d;
      errp_q  <= errp_d;
      errc_q  <= errc_d;
      fault_q <= fault_d;
    end
  end

  assign start_req   = start_q;
  assign index       = index_q;
  assign index_valid = valid_q;
  assign wrap_pulse  = wrap_q;
  assign rot_count   = rot_q;
  assign err_pulse   = errp_q;
  assign err_count   = errc_q;
  assign fault       = fault_q;
endmodule
